// File: rtl/pixel_unpacker.sv
// Unpacks WIDTH-bit packed pixel words into one pixel per output beat, MSB-first,
// at 1/2/4/8 bpp, tracking scanline length and realigning each line to a word start.
module pixel_unpacker #(
    parameter int WIDTH = 16,
    parameter int LW    = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       mode,
    input  logic [LW-1:0]    line_pixels,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_valid,
    output logic             i_ready,
    output logic [7:0]       o_pixel,
    output logic             o_valid,
    input  logic             o_ready,
    output logic             o_last
);

    localparam int RW = $clog2(WIDTH + 1);
    localparam int CW = LW + 1;

    logic [WIDTH-1:0] shreg;
    logic [RW-1:0]    rem;
    logic [CW-1:0]    cnt;
    logic [1:0]       bpp_q;
    logic             line_start;

    logic             out_acc;
    logic             in_acc;
    logic             new_line;
    logic [1:0]       bpp_sel;
    logic [RW-1:0]    ppw;
    logic [CW-1:0]    line_len;
    logic [3:0]       bpp_w;
    logic [7:0]       top8;

    assign o_valid = (rem != '0);
    assign o_last  = o_valid && (cnt == CW'(1));
    assign top8    = shreg[WIDTH-1 -: 8];

    always_comb begin
        o_pixel = 8'd0;
        case (bpp_q)
            2'd0:    o_pixel = {7'd0, top8[7]};
            2'd1:    o_pixel = {6'd0, top8[7:6]};
            2'd2:    o_pixel = {4'd0, top8[7:4]};
            default: o_pixel = top8;
        endcase
    end

    assign out_acc = o_valid && o_ready;

    // A new word may load when the current one is empty or is being drained this cycle,
    // either by its final pixel or by the line ending inside it.
    assign i_ready  = !rst && ((rem == '0) || (out_acc && ((rem == RW'(1)) || o_last)));
    assign in_acc   = i_valid && i_ready;
    assign new_line = line_start || (out_acc && o_last);
    assign bpp_sel  = new_line ? mode : bpp_q;
    assign ppw      = RW'(WIDTH) >> bpp_sel;
    assign line_len = (line_pixels == '0) ? {1'b1, {LW{1'b0}}} : {1'b0, line_pixels};
    assign bpp_w    = 4'd1 << bpp_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg      <= '0;
            rem        <= '0;
            cnt        <= '0;
            bpp_q      <= 2'd0;
            line_start <= 1'b1;
        end else begin
            if (out_acc) begin
                shreg <= shreg << bpp_w;
                rem   <= rem - RW'(1);
                cnt   <= cnt - CW'(1);
                if (o_last) begin
                    rem        <= '0;
                    line_start <= 1'b1;
                end
            end
            if (in_acc) begin
                shreg <= i_data;
                rem   <= ppw;
                if (new_line) begin
                    bpp_q      <= mode;
                    cnt        <= line_len;
                    line_start <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_pixel_unpacker.sv
// Randomized bench for pixel_unpacker: lines are expanded into expected pixel streams
// up front, then the DUT output is scored against them under random handshakes.
module tb_pixel_unpacker;

    localparam int WIDTH = 16;
    localparam int LW    = 12;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [1:0]       mode = 2'd0;
    logic [LW-1:0]    line_pixels = '0;
    logic [WIDTH-1:0] i_data = '0;
    logic             i_valid = 1'b0;
    logic             i_ready;
    logic [7:0]       o_pixel;
    logic             o_valid;
    logic             o_ready = 1'b0;
    logic             o_last;

    pixel_unpacker #(.WIDTH(WIDTH), .LW(LW)) dut (
        .clk         (clk),
        .rst         (rst),
        .mode        (mode),
        .line_pixels (line_pixels),
        .i_data      (i_data),
        .i_valid     (i_valid),
        .i_ready     (i_ready),
        .o_pixel     (o_pixel),
        .o_valid     (o_valid),
        .o_ready     (o_ready),
        .o_last      (o_last)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] data;
        logic [1:0]  mode;
        logic [11:0] lp;
        logic        first;
    } word_t;

    typedef struct packed {
        logic [7:0] pix;
        logic       last;
    } pix_t;

    word_t       word_q[$];
    pix_t        exp_q[$];
    logic [15:0] preset_q[$];
    bit          rdy_pat[$];

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp_v, $time);
        end
    endtask

    // Expand one scanline into its words and the pixels the consumer should see.
    task automatic add_line(input logic [1:0] m, input int lp);
        int len, bpp, ppw, nw, dv;
        logic [15:0] d;
        word_t w;
        pix_t  p;
        len = (lp == 0) ? 4096 : lp;
        bpp = 1 << m;
        ppw = 16 / bpp;
        nw  = (len + ppw - 1) / ppw;
        for (int wi = 0; wi < nw; wi++) begin
            if (preset_q.size() > 0) d = preset_q.pop_front();
            else d = 16'($urandom);
            w.data  = d;
            w.mode  = m;
            w.lp    = 12'(lp);
            w.first = (wi == 0);
            word_q.push_back(w);
            dv = int'(d);
            for (int i = 0; i < ppw; i++) begin
                if (wi * ppw + i < len) begin
                    p.pix  = 8'((dv >> (16 - bpp * (i + 1))) & ((1 << bpp) - 1));
                    p.last = (wi * ppw + i == len - 1);
                    exp_q.push_back(p);
                end
            end
        end
    endtask

    task automatic run(input bit full_speed, input int max_cycles);
        bit         offered, stall_prev, started;
        logic [7:0] prev_pix;
        logic       prev_last;
        pix_t       e;
        offered = 0; stall_prev = 0; started = 0; prev_pix = '0; prev_last = 0;
        for (int c = 0; c < max_cycles && (word_q.size() > 0 || exp_q.size() > 0); c++) begin
            if (word_q.size() > 0 &&
                (offered || full_speed || rdy_pat.size() > 0 || $urandom_range(0, 99) < 70)) begin
                i_valid = 1'b1;
                i_data  = word_q[0].data;
                if (word_q[0].first) begin
                    mode        = word_q[0].mode;
                    line_pixels = word_q[0].lp;
                end else begin
                    mode        = word_q[0].mode + 2'($urandom_range(1, 3));
                    line_pixels = 12'($urandom);
                end
            end else begin
                i_valid     = 1'b0;
                i_data      = 16'($urandom);
                mode        = 2'($urandom);
                line_pixels = 12'($urandom);
            end
            if (rdy_pat.size() > 0) o_ready = rdy_pat.pop_front();
            else o_ready = full_speed ? 1'b1 : ($urandom_range(0, 99) < 60);

            @(negedge clk);
            if (stall_prev) begin
                chk("stall_valid", 32'(o_valid), 32'd1);
                chk("stall_pixel", 32'(o_pixel), 32'(prev_pix));
                chk("stall_last", 32'(o_last), 32'(prev_last));
            end
            if (o_valid && !o_ready) chk("stall_iready", 32'(i_ready), 32'd0);
            if (full_speed && started && exp_q.size() > 0) chk("bubble", 32'(o_valid), 32'd1);
            if (o_valid) begin
                if (exp_q.size() == 0) chk("stale_valid", 32'(o_valid), 32'd0);
                else if (o_ready) begin
                    e = exp_q.pop_front();
                    chk("pixel", 32'(o_pixel), 32'(e.pix));
                    chk("last", 32'(o_last), 32'(e.last));
                    started = 1;
                end
            end
            stall_prev = o_valid && !o_ready;
            prev_pix   = o_pixel;
            prev_last  = o_last;
            if (i_valid && i_ready) begin
                void'(word_q.pop_front());
                offered = 0;
            end else begin
                offered = i_valid;
            end
            @(posedge clk); #1;
        end
        chk("drain_words", 32'(word_q.size()), 32'd0);
        chk("drain_pixels", 32'(exp_q.size()), 32'd0);
        i_valid = 1'b0;
        o_ready = 1'b0;
        word_q.delete();
        exp_q.delete();
        rdy_pat.delete();
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_iready_held", 32'(i_ready), 32'd0);
        chk("rst_ovalid_held", 32'(o_valid), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ovalid", 32'(o_valid), 32'd0);
        chk("post_rst_olast", 32'(o_last), 32'd0);
        chk("post_rst_opixel", 32'(o_pixel), 32'd0);
        chk("post_rst_iready", 32'(i_ready), 32'd1);
        @(posedge clk); #1;

        // Full-throughput directed lines: aligned end, mid-word end, 1bpp, mode change mid-line
        preset_q.push_back(16'h1234); preset_q.push_back(16'hABCD);
        add_line(2'd2, 8);
        preset_q.push_back(16'h1234); preset_q.push_back(16'h5678);
        add_line(2'd2, 6);
        preset_q.push_back(16'h9ABC);
        add_line(2'd2, 4);
        preset_q.push_back(16'h8001);
        add_line(2'd0, 16);
        preset_q.push_back(16'h1234); preset_q.push_back(16'h5678);
        add_line(2'd2, 6);
        preset_q.push_back(16'h1122); preset_q.push_back(16'h3344);
        add_line(2'd3, 4);
        run(1'b1, 2000);

        // Stall pattern on an 8bpp word
        preset_q.push_back(16'hC355);
        add_line(2'd3, 2);
        rdy_pat.push_back(1); rdy_pat.push_back(0); rdy_pat.push_back(0);
        rdy_pat.push_back(1); rdy_pat.push_back(1);
        run(1'b1, 200);

        // line_pixels = 0 means the full 2^LW pixel line
        add_line(2'd3, 0);
        run(1'b1, 6000);

        for (int l = 0; l < 40; l++) add_line(2'($urandom), $urandom_range(1, 40));
        run(1'b0, 20000);

        // Reset in the middle of a line
        i_valid = 1'b1; i_data = 16'h1234; mode = 2'd2; line_pixels = 12'd8; o_ready = 1'b1;
        @(negedge clk);
        chk("mid_rst_accept", 32'(i_ready), 32'd1);
        @(posedge clk); #1;
        i_valid = 1'b0;
        @(negedge clk);
        chk("mid_rst_p1", 32'(o_pixel), 32'h1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("mid_rst_p2", 32'(o_pixel), 32'h2);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_iready", 32'(i_ready), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_ovalid", 32'(o_valid), 32'd0);
        chk("mid_rst_olast", 32'(o_last), 32'd0);
        chk("mid_rst_iready_up", 32'(i_ready), 32'd1);
        @(posedge clk); #1;
        preset_q.push_back(16'hF000);
        add_line(2'd2, 3);
        run(1'b0, 500);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/pixel_unpacker.md
Name: pixel_unpacker

Overview:
- Downstream consumer of the fetch-path skid buffer.
- Takes packed WIDTH-bit pixel words on a valid/ready handshake and emits one pixel per accepted output beat, MSB-first, at 1/2/4/8 bpp.
- Tracks pixels per scanline and flags the last pixel of each line.
- Discards leftover pixels in a partially used word at line end, so every line starts word-aligned.
- Feeds the palette/line-buffer stage.

Parameters:
- WIDTH, 16, packed input word width; must be a multiple of 8.
- LW, 12, width of line length field; 0 encodes 2^LW pixels.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, synchronous, active-high.
- mode  input  2  bpp select: 0=1bpp, 1=2bpp, 2=4bpp, 3=8bpp; sampled at line start.
- line_pixels  input  LW  pixels per line; sampled at line start.
- i_data  input  WIDTH  packed pixel word.
- i_valid  input  1  word valid.
- i_ready  output  1  unpacker can take a word this cycle.
- o_pixel  output  8  current pixel, zero-extended from bpp bits.
- o_valid  output  1  o_pixel valid.
- o_ready  input  1  downstream accepts pixel.
- o_last  output  1  o_pixel is last pixel of the line; qualified by o_valid.

Behaviour:
- State:
  - shreg: WIDTH-bit word register.
  - rem: pixels left in shreg, 0..WIDTH.
  - cnt: pixels remaining in line, LW+1 bits.
  - bpp_q: latched mode.
  - line_start flag.
- Reset: rem=0, o_valid=0, o_last=0, o_pixel=0, line_start=1, cnt=0, shreg=0. i_ready=0 while rst is high; i_ready=1 the first cycle after.
- Output:
  - o_valid = (rem!=0).
  - o_pixel = top bpp bits of shreg, zero-extended.
  - o_last = o_valid && (cnt==1).
  - All are functions of registers only; no combinational path from i_* to o_*.
- Output accept (o_valid && o_ready):
  - shreg shifts left by bpp, rem--, cnt--.
  - If o_last: rem<=0 (remaining pixels in word dropped), line_start<=1.
- Input accept (i_valid && i_ready):
  - i_ready = (rem==0) || (o_valid && o_ready && (rem==1 || o_last)).
  - Full throughput, no bubble between words.
- On word accept:
  - shreg<=i_data, rem<=WIDTH/bpp.
  - If line_start (or o_last is being accepted the same cycle): latch bpp_q from mode; cnt<=line_pixels (0 -> 2^LW); line_start<=0.
  - Otherwise bpp_q and cnt carry on.
- Latency: word accepted in cycle N -> first pixel o_valid in cycle N+1.
- Pixels per word: 16/8/4/2 for WIDTH=16 at 1/2/4/8 bpp.
- Stall: while o_valid && !o_ready, o_pixel, o_last and o_valid are held stable and i_ready=0.
- mode or line_pixels changes mid-line have no effect until the next line start.
- Line ends exactly on a word boundary: the next word is accepted the same cycle as o_last and starts the new line.
- Reset mid-line: all state cleared next cycle. The next accepted word starts a new line at its MSB pixel using current mode/line_pixels.
- No o_valid without a preceding i_valid; upstream idle produces bubbles only, never stale pixels.

Test Plan:
1. mode=2, line_pixels=8, words 0x1234,0xABCD back-to-back, o_ready=1 -> pixels 1,2,3,4,A,B,C,D on consecutive cycles; o_last only on D; i_ready=1 in the cycle pixel 4 is accepted.
2. mode=2, line_pixels=6, words 0x1234,0x5678,0x9ABC -> 1,2,3,4,5,6 with o_last on 6; 7,8 never appear; next line begins 9,A,B,C.
3. mode=0, line_pixels=16, word 0x8001 -> 1 then fourteen 0s then 1 (o_last); 16 beats from one word.
4. mode=3, o_ready pattern 1,0,0,1,1; word 0xC355 -> C3 held stable for 3 cycles, then 55; i_ready=0 during stall.
5. Switch mode 2->3 after the 2nd pixel of a line -> the rest of the line stays at 4 bpp; the next line uses 8 bpp.
6. Assert rst after 2 pixels of 0x1234 -> o_valid=0 the next cycle; next word 0xF000 yields F first, with a new line count.
